// File: rtl/uart_cmd_ctrl.sv
// uart_cmd_ctrl: turns a framed UART byte stream into key/data loads and
// start pulses for a crypto core.
// Frame: A5, CMD, [16 payload bytes for CMD 01/02], CHK (XOR of CMD+payload).
module uart_cmd_ctrl #(
    parameter int TIMEOUT_CLKS = 20832
) (
    input  logic         i_Clock,
    input  logic         i_Reset,
    input  logic         i_Rx_DV,
    input  logic [7:0]   i_Rx_Byte,
    input  logic         i_Busy,
    output logic [127:0] o_Key,
    output logic [127:0] o_Data,
    output logic         o_Start,
    output logic         o_Frame_Err,
    output logic         o_Ready
);

    localparam int TW = $clog2(TIMEOUT_CLKS + 1);
    localparam logic [TW-1:0] TMO_LAST = TW'(TIMEOUT_CLKS - 1);

    localparam logic [7:0] SYNC      = 8'hA5;
    localparam logic [7:0] CMD_KEY   = 8'h01;
    localparam logic [7:0] CMD_DATA  = 8'h02;
    localparam logic [7:0] CMD_START = 8'h03;

    typedef enum logic [2:0] {
        S_IDLE, S_CMD, S_PAYLOAD, S_CHECK, S_ISSUE
    } state_t;

    state_t         state_q, state_d;
    logic [7:0]     cmd_q, cmd_d;
    logic [127:0]   shadow_q, shadow_d;
    logic [7:0]     chk_q, chk_d;
    logic [3:0]     cnt_q, cnt_d;
    logic [TW-1:0]  tmo_q, tmo_d;
    logic [127:0]   key_q, key_d;
    logic [127:0]   data_q, data_d;
    logic           start_q, start_d;
    logic           ferr_q, ferr_d;
    logic           in_frame;
    logic           tmo_hit;

    // tmo_q counts cycles elapsed since the last accepted byte (the strobe
    // cycle itself is cycle 0). Firing when the next value reaches the limit
    // lands the registered error pulse TIMEOUT_CLKS-1 cycles after that byte.
    assign in_frame = (state_q == S_CMD) || (state_q == S_PAYLOAD) || (state_q == S_CHECK);
    assign tmo_hit  = (tmo_q + TW'(1)) == TMO_LAST;

    // Next-state, datapath and output-pulse logic
    always_comb begin
        state_d  = state_q;
        cmd_d    = cmd_q;
        shadow_d = shadow_q;
        chk_d    = chk_q;
        cnt_d    = cnt_q;
        tmo_d    = '0;
        key_d    = key_q;
        data_d   = data_q;
        start_d  = 1'b0;
        ferr_d   = 1'b0;

        case (state_q)
            S_IDLE: begin
                if (i_Rx_DV && i_Rx_Byte == SYNC) begin
                    state_d  = S_CMD;
                    shadow_d = '0;
                    chk_d    = '0;
                    tmo_d    = TW'(1);
                end
            end
            S_CMD: begin
                if (i_Rx_DV) begin
                    tmo_d = TW'(1);
                    cmd_d = i_Rx_Byte;
                    chk_d = i_Rx_Byte;
                    case (i_Rx_Byte)
                        CMD_KEY, CMD_DATA: begin
                            cnt_d   = '0;
                            state_d = S_PAYLOAD;
                        end
                        CMD_START: state_d = S_CHECK;
                        default: begin
                            ferr_d  = 1'b1;
                            state_d = S_IDLE;
                        end
                    endcase
                end
            end
            S_PAYLOAD: begin
                if (i_Rx_DV) begin
                    tmo_d    = TW'(1);
                    shadow_d = {shadow_q[119:0], i_Rx_Byte};
                    chk_d    = chk_q ^ i_Rx_Byte;
                    cnt_d    = cnt_q + 4'd1;
                    if (cnt_q == 4'd15) state_d = S_CHECK;
                end
            end
            S_CHECK: begin
                if (i_Rx_DV) begin
                    state_d = S_IDLE;
                    if (i_Rx_Byte != chk_q) begin
                        ferr_d = 1'b1;
                    end else begin
                        case (cmd_q)
                            CMD_KEY:  key_d  = shadow_q;
                            CMD_DATA: data_d = shadow_q;
                            default: begin
                                // Core already free: start now to keep the
                                // one-cycle CHK-to-start latency.
                                if (!i_Busy) start_d = 1'b1;
                                else         state_d = S_ISSUE;
                            end
                        endcase
                    end
                end
            end
            S_ISSUE: begin
                // Incoming bytes are dropped; wait for the core indefinitely.
                if (!i_Busy) begin
                    start_d = 1'b1;
                    state_d = S_IDLE;
                end
            end
            default: state_d = S_IDLE;
        endcase

        // Inter-byte timeout; a byte in the same cycle takes precedence.
        if (in_frame && !i_Rx_DV) begin
            if (tmo_hit) begin
                ferr_d   = 1'b1;
                state_d  = S_IDLE;
                shadow_d = '0;
                tmo_d    = '0;
            end else begin
                tmo_d = tmo_q + TW'(1);
            end
        end
    end

    // State and output registers, cleared asynchronously
    always_ff @(posedge i_Clock or posedge i_Reset) begin
        if (i_Reset) begin
            state_q  <= S_IDLE;
            cmd_q    <= '0;
            shadow_q <= '0;
            chk_q    <= '0;
            cnt_q    <= '0;
            tmo_q    <= '0;
            key_q    <= '0;
            data_q   <= '0;
            start_q  <= 1'b0;
            ferr_q   <= 1'b0;
        end else begin
            state_q  <= state_d;
            cmd_q    <= cmd_d;
            shadow_q <= shadow_d;
            chk_q    <= chk_d;
            cnt_q    <= cnt_d;
            tmo_q    <= tmo_d;
            key_q    <= key_d;
            data_q   <= data_d;
            start_q  <= start_d;
            ferr_q   <= ferr_d;
        end
    end

    assign o_Key       = key_q;
    assign o_Data      = data_q;
    assign o_Start     = start_q;
    assign o_Frame_Err = ferr_q;
    assign o_Ready     = (state_q == S_IDLE);

endmodule

// File: tb/tb_uart_cmd_ctrl.sv
// Directed bench for uart_cmd_ctrl with a short timeout.
module tb_uart_cmd_ctrl;

    localparam int T = 40;
    localparam logic [127:0] SEQ  = 128'h000102030405060708090A0B0C0D0E0F;
    localparam logic [127:0] A5S  = {16{8'hA5}};

    logic         clk = 1'b0;
    logic         rst = 1'b0;
    logic         rx_dv = 1'b0;
    logic [7:0]   rx_byte = 8'h00;
    logic         busy = 1'b0;
    logic [127:0] key, data;
    logic         start, ferr, ready;

    int n_chk  = 0;
    int n_fail = 0;

    uart_cmd_ctrl #(.TIMEOUT_CLKS(T)) dut (
        .i_Clock(clk), .i_Reset(rst), .i_Rx_DV(rx_dv), .i_Rx_Byte(rx_byte),
        .i_Busy(busy), .o_Key(key), .o_Data(data), .o_Start(start),
        .o_Frame_Err(ferr), .o_Ready(ready)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [127:0] obs, input logic [127:0] exp);
        n_chk++;
        if (obs !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h want %h", tag, obs, exp);
        end
    endtask

    // One-cycle strobe; returns just after the edge that sampled the byte.
    task automatic send_byte(input logic [7:0] b);
        @(posedge clk); #1;
        rx_dv = 1'b1; rx_byte = b;
        @(posedge clk); #1;
        rx_dv = 1'b0;
    endtask

    task automatic send_pl(input logic [127:0] pl);
        logic [127:0] p;
        p = pl;
        for (int i = 0; i < 16; i++) begin
            send_byte(p[127:120]);
            p = p << 8;
        end
    endtask

    task automatic tick;
        @(posedge clk); #1;
    endtask

    initial begin
        int starts;
        int lat;
        bit seen;

        #1 rst = 1'b1;
        #1;
        check("rst_key", key, 128'h0);
        check("rst_data", data, 128'h0);
        check("rst_start", {127'h0, start}, 128'h0);
        check("rst_ferr", {127'h0, ferr}, 128'h0);
        check("rst_ready", {127'h0, ready}, 128'h1);
        repeat (2) @(negedge clk);
        rst = 1'b0;

        // Key load: chk = 01 ^ (00^..^0F) = 01
        send_byte(8'hA5);
        check("ready_in_frame", {127'h0, ready}, 128'h0);
        send_byte(8'h01); send_pl(SEQ); send_byte(8'h01);
        check("key_load", key, SEQ);
        check("key_noerr", {127'h0, ferr}, 128'h0);
        check("key_ready", {127'h0, ready}, 128'h1);

        // Same frame, bad checksum
        send_byte(8'hA5); send_byte(8'h01); send_pl(128'h0); send_byte(8'h00);
        check("badchk_err", {127'h0, ferr}, 128'h1);
        check("badchk_key", key, SEQ);
        tick;
        check("badchk_pulse1", {127'h0, ferr}, 128'h0);

        // Data load of all-A5 payload (A5 mid-frame is data): chk = 02
        send_byte(8'hA5); send_byte(8'h02); send_pl(A5S); send_byte(8'h02);
        check("data_a5", data, A5S);
        check("data_key_kept", key, SEQ);

        // Start with core idle: pulse one cycle after CHK
        busy = 1'b0;
        send_byte(8'hA5); send_byte(8'h03); send_byte(8'h03);
        check("start_now", {127'h0, start}, 128'h1);
        check("start_noerr", {127'h0, ferr}, 128'h0);
        tick;
        check("start_pulse1", {127'h0, start}, 128'h0);

        // Start held off by busy; a byte in ISSUE is dropped
        busy = 1'b1;
        send_byte(8'hA5); send_byte(8'h03); send_byte(8'h03);
        starts = int'(start);
        check("issue_ready", {127'h0, ready}, 128'h0);
        repeat (20) begin tick; starts += int'(start); end
        send_byte(8'h11);
        starts += int'(start);
        repeat (28) begin tick; starts += int'(start); end
        check("busy_nostart", 128'(starts), 128'h0);
        busy = 1'b0;
        tick;
        check("busy_start", {127'h0, start}, 128'h1);
        tick;
        check("busy_start_pulse1", {127'h0, start}, 128'h0);
        check("busy_ready", {127'h0, ready}, 128'h1);

        // Timeout: pulse T-1 cycles after the last byte's strobe cycle,
        // i.e. visible after T-2 further edges.
        send_byte(8'hA5); send_byte(8'h02);
        for (int i = 0; i < 5; i++) send_byte(8'h10 + 8'(i));
        seen = 1'b0; lat = 0;
        for (int i = 1; i <= 2 * T && !seen; i++) begin
            tick;
            if (ferr) begin seen = 1'b1; lat = i; end
        end
        check("tmo_latency", 128'(lat), 128'(T - 2));
        check("tmo_data_kept", data, A5S);
        send_byte(8'hA5); send_byte(8'h02); send_pl(SEQ); send_byte(8'h02);
        check("tmo_next_frame", data, SEQ);
        check("tmo_next_noerr", {127'h0, ferr}, 128'h0);

        // Illegal command, then noise in IDLE
        send_byte(8'hA5); send_byte(8'h7F);
        check("badcmd_err", {127'h0, ferr}, 128'h1);
        send_byte(8'h11);
        check("noise1", {127'h0, ferr}, 128'h0);
        send_byte(8'h22);
        check("noise2", {127'h0, ferr}, 128'h0);
        check("noise_ready", {127'h0, ready}, 128'h1);

        // Asynchronous reset mid-payload
        send_byte(8'hA5); send_byte(8'h01);
        send_byte(8'h00); send_byte(8'h01); send_byte(8'h02);
        @(negedge clk); #2;
        rst = 1'b1;
        #1;
        check("arst_key", key, 128'h0);
        check("arst_data", data, 128'h0);
        check("arst_ready", {127'h0, ready}, 128'h1);
        check("arst_start_ferr", {126'h0, start, ferr}, 128'h0);
        @(negedge clk);
        rst = 1'b0;
        send_byte(8'hA5); send_byte(8'h01); send_pl(SEQ); send_byte(8'h01);
        check("post_rst_key", key, SEQ);

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule

// File: doc/uart_cmd_ctrl.md
UART_CMD_CTRL -- requirements
Module: uart_cmd_ctrl

Interface
REQ-001 Parameter TIMEOUT_CLKS, default 20832, inter-byte timeout in i_Clock cycles (two byte times at 9600 baud from a 10 MHz clock).
REQ-002 i_Clock  input  1  sole clock; all state updates on its rising edge.
REQ-003 i_Reset  input  1  asynchronous, active-high reset.
REQ-004 i_Rx_DV  input  1  one-cycle strobe from the UART receiver; i_Rx_Byte is valid while it is high.
REQ-005 i_Rx_Byte  input  8  received byte.
REQ-006 i_Busy  input  1  crypto core busy; start requests must wait while it is high.
REQ-007 o_Key  output  128  committed key register, first payload byte in bits [127:120].
REQ-008 o_Data  output  128  committed data register, same byte order as o_Key.
REQ-009 o_Start  output  1  one-cycle start pulse to the crypto core.
REQ-010 o_Frame_Err  output  1  one-cycle pulse on any rejected frame.
REQ-011 o_Ready  output  1  high only in IDLE.

Function
REQ-012 Frame format: sync 0xA5, then CMD, then 16 payload bytes (CMD 0x01 or 0x02 only), then CHK; CHK = XOR of CMD and all payload bytes.
REQ-013 Commands: 0x01 = load key, 0x02 = load data, 0x03 = start; 0x03 carries no payload, so its CHK = 0x03.
REQ-014 States: IDLE, CMD, PAYLOAD, CHECK, ISSUE; bytes are consumed only in cycles where i_Rx_DV = 1.
REQ-015 IDLE: byte 0xA5 -> CMD; any other byte is ignored silently, with no error pulse.
REQ-016 CMD: 0x01/0x02 -> PAYLOAD with byte count cleared; 0x03 -> CHECK; any other value -> o_Frame_Err pulse and return to IDLE.
REQ-017 PAYLOAD: each byte shifts into a 128-bit shadow register (shifted left by 8, new byte into [7:0]); the 4-bit byte count wraps from 15 to 0, and the 16th byte moves to CHECK.
REQ-018 Running XOR checksum is loaded with CMD in state CMD and updated with every payload byte.
REQ-019 CHECK, mismatch -> o_Frame_Err pulse the next cycle, return to IDLE; o_Key and o_Data unchanged.
REQ-020 CHECK, match, CMD 0x01 -> copy shadow to o_Key on the next edge, return to IDLE; CMD 0x02 -> same, to o_Data.
REQ-021 CHECK, match, CMD 0x03 -> ISSUE.
REQ-022 ISSUE: o_Start = 1 for exactly one cycle in the first cycle in which i_Busy = 0, then return to IDLE; if i_Busy stays high, remain in ISSUE indefinitely (no timeout).
REQ-023 Bytes arriving while in ISSUE are discarded.
REQ-024 Timeout: a counter clears on every accepted byte and on entry to CMD; in CMD, PAYLOAD or CHECK, reaching TIMEOUT_CLKS-1 -> o_Frame_Err pulse and return to IDLE, shadow discarded.
REQ-025 If i_Rx_DV and the timeout fall in the same cycle, the byte wins and the counter clears.
REQ-026 0xA5 received mid-frame is treated as ordinary data; there is no resynchronisation.
REQ-027 All outputs are registered; latency from CHK strobe to o_Key/o_Data update or o_Start (i_Busy low) is 1 cycle.
REQ-028 o_Frame_Err and o_Start are never high in the same cycle.

Reset
REQ-029 i_Reset asserted: state = IDLE, o_Key = 0, o_Data = 0, shadow = 0, checksum = 0, counters = 0, o_Start = 0, o_Frame_Err = 0, o_Ready = 1; applied immediately, regardless of clock.
REQ-030 Reset mid-frame abandons the frame; committed registers are cleared, not preserved.
REQ-031 First byte accepted after reset is evaluated in IDLE.

Verification
REQ-032 Bytes A5,01,00..0F,01 (XOR of 01 and 00..0F = 01) -> o_Key = 0x000102030405060708090A0B0C0D0E0F one cycle after CHK; o_Frame_Err stays 0.
REQ-033 Same frame with CHK = 0x00 -> o_Frame_Err one-cycle pulse; o_Key unchanged.
REQ-034 A5,03,03 with i_Busy = 1 for 50 cycles -> no o_Start while busy; o_Start single pulse the cycle after i_Busy falls; o_Ready high the next cycle.
REQ-035 A5,02 + 5 payload bytes then silence -> o_Frame_Err exactly TIMEOUT_CLKS-1 cycles after the last byte; o_Data unchanged; next valid frame accepted.
REQ-036 A5,7F -> o_Frame_Err pulse; bytes 11,22 in IDLE -> no error; i_Reset pulsed mid-PAYLOAD -> all outputs at reset values asynchronously.
